// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of the UART tx FIFO write port; a grant is held for a whole packet.
// Optional header byte before each packet: define UART_TX_ARB_HDR_EN.
//
// state  | meaning
// IDLE   | no grant; pick the next valid requester from the rr pointer (one cycle)
// HDR    | (UART_TX_ARB_HDR_EN only) write {1, 0.., grant_id} ahead of the payload
// XFER   | forward the granted requester's bytes until last or stall timeout
module uart_tx_arbiter #(
  parameter int dbits       = 8,
  parameter int NREQ        = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         s_valid,
  input  logic [NREQ*dbits-1:0]   s_data,
  input  logic [NREQ-1:0]         s_last,
  output logic [NREQ-1:0]         s_ready,
  input  logic                    tx_full,
  output logic                    wr_uart,
  output logic [dbits-1:0]        w_data,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    stall_abort
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [GW-1:0] LAST_ID  = GW'(NREQ - 1);
  localparam logic [CW-1:0] STALL_TC = CW'(STALL_LIMIT - 1);

`ifdef UART_TX_ARB_HDR_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR, S_XFER} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_XFER} state_t;
`endif

  state_t          state;
  logic [GW-1:0]   rr_ptr;
  logic [CW-1:0]   stall_cnt;
  logic [dbits-1:0] req_byte [NREQ];
  logic            g_valid;
  logic            g_last;
  logic            arb_found;
  logic [GW-1:0]   arb_idx;
  logic [GW-1:0]   next_ptr;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign req_byte[g] = s_data[g*dbits +: dbits];
  end

  assign g_valid  = s_valid[grant_id];
  assign g_last   = s_last[grant_id];
  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + GW'(1);

  // Walk offsets from the far end so the lowest offset from rr_ptr wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int j;
      j = int'(rr_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (s_valid[j]) begin
        arb_found = 1'b1;
        arb_idx   = GW'(j);
      end
    end
  end

`ifdef UART_TX_ARB_HDR_EN
  logic [dbits-1:0] hdr_byte;
  always_comb begin
    hdr_byte            = '0;
    hdr_byte[dbits-1]   = 1'b1;
    hdr_byte[GW-1:0]    = grant_id;
  end
`endif

  // Write path is combinational so a byte moves in the same cycle it is offered.
  always_comb begin
    wr_uart = 1'b0;
    s_ready = '0;
    w_data  = '0;
    case (state)
      S_XFER: begin
        wr_uart           = g_valid & ~tx_full;
        s_ready[grant_id] = g_valid & ~tx_full;
        w_data            = req_byte[grant_id];
      end
`ifdef UART_TX_ARB_HDR_EN
      S_HDR: begin
        wr_uart = ~tx_full;
        w_data  = hdr_byte;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      stall_cnt   <= '0;
      stall_abort <= 1'b0;
    end else begin
      stall_abort <= 1'b0;
      case (state)
        S_IDLE: begin
          stall_cnt <= '0;
          if (arb_found) begin
            grant_id <= arb_idx;
            busy     <= 1'b1;
`ifdef UART_TX_ARB_HDR_EN
            state    <= S_HDR;
`else
            state    <= S_XFER;
`endif
          end
        end
`ifdef UART_TX_ARB_HDR_EN
        S_HDR: begin
          stall_cnt <= '0;
          if (!tx_full) state <= S_XFER;
        end
`endif
        S_XFER: begin
          // A valid byte held off by tx_full is backpressure, not a stall.
          if (g_valid) begin
            stall_cnt <= '0;
            if (!tx_full && g_last) begin
              state  <= S_IDLE;
              busy   <= 1'b0;
              rr_ptr <= next_ptr;
            end
          end else if (stall_cnt == STALL_TC) begin
            stall_cnt   <= '0;
            stall_abort <= 1'b1;
            state       <= S_IDLE;
            busy        <= 1'b0;
            rr_ptr      <= next_ptr;
          end else begin
            stall_cnt <= stall_cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
